// File: rtl/intr_ctrl_if.sv
// Signal bundle between intr_ctrl (slave side), the peripheral IRQ lines and the pipeline/CP0 pair (master side).
// Handshake: int_req_o is a registered request held high until ack_i; a request can also be withdrawn while ack_i stays low.
interface intr_if;
   logic [5:0]  irq_i;
   logic [31:0] status_i;
   logic [31:0] pc_i;
   logic        ack_i;
   logic        eret_i;
   logic        int_req_o;
   logic        exception_o;
   logic [31:0] epc_o;
   logic [5:0]  ext_int_o;
   logic [31:0] vector_o;
   logic        in_service_o;
   logic [1:0]  fsm_state;

   modport master (
      output irq_i, status_i, pc_i, ack_i, eret_i,
      input  int_req_o, exception_o, epc_o, ext_int_o, vector_o, in_service_o, fsm_state
   );

   modport slave (
      input  irq_i, status_i, pc_i, ack_i, eret_i,
      output int_req_o, exception_o, epc_o, ext_int_o, vector_o, in_service_o, fsm_state
   );
endinterface

// File: rtl/intr_ctrl.sv
// Interrupt controller: IRQ synchronisers, Status masking, request/ack handshake, CP0 exception hand-off.
// Define INTR_EDGE_EN for edge-triggered pending bits; the default build is level-triggered.
module intr_ctrl #(
   parameter int          SYNC_STAGES  = 2,
   parameter logic [31:0] HANDLER_ADDR = 32'h0000_F000
) (
   input logic clk,
   input logic rst,
   intr_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t                      state;
   logic [SYNC_STAGES-1:0][5:0] sync_q;
   logic [5:0]                  sync;
   logic [5:0]                  pend;
   logic [5:0]                  masked;
   logic [5:0]                  snap;
   logic [5:0]                  cur_snap;
   logic                        ack_fire;
   logic                        int_req;
   logic                        exception;
   logic                        in_service;
   logic [31:0]                 epc;
   logic [5:0]                  ext_int;
   logic                        unused_status;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.irq_i};
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];

`ifdef INTR_EDGE_EN
   logic [5:0] sync_d;
   logic [5:0] pend_q;
   logic [5:0] served;

   // Isolate the lowest set bit of the snapshot being acknowledged.
   assign served = cur_snap & (~cur_snap + 6'd1);

   // A new rising edge on a bit being cleared wins over the clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_d <= '0;
         pend_q <= '0;
      end else begin
         sync_d <= sync;
         pend_q <= (pend_q & ~(ack_fire ? served : 6'd0)) | (sync & ~sync_d);
      end
   end

   assign pend = pend_q;
`else
   assign pend = sync;
`endif

   assign masked   = pend & bus.status_i[15:10] & {6{bus.status_i[0]}};
   assign cur_snap = (masked != 6'd0) ? masked : snap;
   assign ack_fire = (state == REQ) && bus.ack_i;

   assign unused_status = ^{bus.status_i[31:16], bus.status_i[9:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         snap       <= '0;
         int_req    <= 1'b0;
         exception  <= 1'b0;
         in_service <= 1'b0;
         epc        <= '0;
         ext_int    <= '0;
      end else begin
         exception <= 1'b0;
         case (state)
            IDLE: begin
               if (masked != 6'd0) begin
                  state   <= REQ;
                  int_req <= 1'b1;
                  snap    <= masked;
               end
            end
            REQ: begin
               if (masked != 6'd0) begin
                  snap <= masked;
               end
               // An ack arriving as the source vanishes is still honoured.
               if (bus.ack_i) begin
                  state      <= SERVICE;
                  int_req    <= 1'b0;
                  in_service <= 1'b1;
                  exception  <= 1'b1;
                  epc        <= bus.pc_i;
                  ext_int    <= cur_snap;
               end else if (masked == 6'd0) begin
                  state   <= IDLE;
                  int_req <= 1'b0;
               end
            end
            SERVICE: begin
               if (bus.eret_i) begin
                  state      <= IDLE;
                  in_service <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               int_req    <= 1'b0;
               in_service <= 1'b0;
            end
         endcase
      end
   end

   assign bus.int_req_o    = int_req;
   assign bus.exception_o  = exception;
   assign bus.in_service_o = in_service;
   assign bus.epc_o        = epc;
   assign bus.ext_int_o    = ext_int;
   assign bus.vector_o     = HANDLER_ADDR;
   assign bus.fsm_state    = state;

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed scenarios then random traffic, checked each cycle against a reference model.
module tb_intr_ctrl;
   localparam int          SYNC_STAGES  = 2;
   localparam logic [31:0] HANDLER_ADDR = 32'h0000_F000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   intr_if bus ();

   intr_ctrl #(
      .SYNC_STAGES (SYNC_STAGES),
      .HANDLER_ADDR(HANDLER_ADDR)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Reference model: irq history, pending set, request/service flags and CP0 outputs.
   logic [5:0]  hist[$];
   logic [5:0]  m_pend;
   logic [5:0]  m_snap;
   logic [5:0]  m_ext;
   logic [31:0] m_epc;
   bit          m_req;
   bit          m_svc;
   bit          m_exc;

   function automatic logic [5:0] sync_at(input int age);
      return (hist.size() > age) ? hist[age] : 6'd0;
   endfunction

   function automatic logic [5:0] lowest(input logic [5:0] v);
      logic [5:0] r;
      r = 6'd0;
      for (int i = 5; i >= 0; i--) begin
         if (v[i]) r = 6'd0;
         if (v[i]) r[i] = 1'b1;
      end
      return r;
   endfunction

   task automatic model_reset();
      hist.delete();
      m_pend = 6'd0;
      m_snap = 6'd0;
      m_ext  = 6'd0;
      m_epc  = 32'd0;
      m_req  = 0;
      m_svc  = 0;
      m_exc  = 0;
   endtask

   task automatic model_edge();
      logic [5:0] now, prev, pend, masked, cur, clr;
      if (rst) begin
         model_reset();
         return;
      end
      now  = sync_at(SYNC_STAGES - 1);
      prev = sync_at(SYNC_STAGES);
`ifdef INTR_EDGE_EN
      pend = m_pend;
`else
      pend = now;
`endif
      masked = pend & bus.status_i[15:10] & {6{bus.status_i[0]}};
      clr    = 6'd0;
      m_exc  = 0;
      if (m_svc) begin
         if (bus.eret_i) m_svc = 0;
      end else if (m_req) begin
         cur = (masked != 6'd0) ? masked : m_snap;
         if (masked != 6'd0) m_snap = masked;
         if (bus.ack_i) begin
            m_epc = bus.pc_i;
            m_ext = cur;
            m_exc = 1;
            m_req = 0;
            m_svc = 1;
            clr   = lowest(cur);
         end else if (masked == 6'd0) begin
            m_req = 0;
         end
      end else if (masked != 6'd0) begin
         m_req  = 1;
         m_snap = masked;
      end
`ifdef INTR_EDGE_EN
      m_pend = (m_pend & ~clr) | (now & ~prev);
`endif
      hist.push_front(bus.irq_i);
      if (hist.size() > SYNC_STAGES + 1) void'(hist.pop_back());
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      chk("int_req", {31'd0, bus.int_req_o}, {31'd0, m_req});
      chk("exception", {31'd0, bus.exception_o}, {31'd0, m_exc});
      chk("in_service", {31'd0, bus.in_service_o}, {31'd0, m_svc});
      chk("epc", bus.epc_o, m_epc);
      chk("ext_int", {26'd0, bus.ext_int_o}, {26'd0, m_ext});
      chk("vector", bus.vector_o, HANDLER_ADDR);
      chk("state_legal", {31'd0, bus.fsm_state != 2'd3}, 32'd1);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   initial begin
      bus.irq_i    = 6'd0;
      bus.status_i = 32'd0;
      bus.pc_i     = 32'd0;
      bus.ack_i    = 1'b0;
      bus.eret_i   = 1'b0;
      model_reset();
      #1 rst = 1'b1;
      #1 check_all();
      run(2);
      rst = 1'b0;

      // Basic level request, ack and eret.
      bus.status_i = 32'h0000_0401;
      bus.irq_i    = 6'b000001;
      run(3);
      bus.ack_i = 1'b1;
      bus.pc_i  = 32'h0000_0100;
      run(1);
      bus.ack_i = 1'b0;
      bus.pc_i  = 32'h0000_0200;
      run(3);
      bus.irq_i  = 6'd0;
      bus.eret_i = 1'b1;
      run(1);
      bus.eret_i = 1'b0;
      run(4);

      // IE cleared: no request, then IE set.
      bus.status_i = 32'h0000_0400;
      bus.irq_i    = 6'b000001;
      run(20);
      bus.status_i = 32'h0000_0401;
      run(3);

      // Withdraw without ack.
`ifdef INTR_EDGE_EN
      bus.status_i = 32'h0000_0001;
`else
      bus.irq_i = 6'd0;
`endif
      run(5);
      bus.irq_i = 6'd0;
      run(3);

      // Nesting block during service.
      bus.status_i = 32'h0000_0C01;
      bus.irq_i    = 6'b000001;
      run(3);
      bus.ack_i = 1'b1;
      bus.pc_i  = 32'h0000_0300;
      run(1);
      bus.ack_i = 1'b0;
      bus.irq_i = 6'b000010;
      run(6);
      bus.eret_i = 1'b1;
      run(1);
      bus.eret_i = 1'b0;
      run(2);
      bus.ack_i = 1'b1;
      bus.pc_i  = 32'h0000_0400;
      run(1);
      bus.ack_i = 1'b0;
      bus.irq_i = 6'd0;
      run(2);
      bus.eret_i = 1'b1;
      run(1);
      bus.eret_i = 1'b0;
      run(4);

      // Pulses on irq[3] and irq[1].
      bus.status_i = 32'h0000_FC01;
      bus.irq_i    = 6'b001010;
      run(1);
      bus.irq_i = 6'd0;
      run(4);
      bus.ack_i = 1'b1;
      bus.pc_i  = 32'h0000_0500;
      run(1);
      bus.ack_i = 1'b0;
      run(3);
      bus.eret_i = 1'b1;
      run(1);
      bus.eret_i = 1'b0;
      run(3);
      bus.ack_i = 1'b1;
      bus.pc_i  = 32'h0000_0600;
      run(1);
      bus.ack_i = 1'b0;
      run(2);
      bus.eret_i = 1'b1;
      run(1);
      bus.eret_i = 1'b0;
      bus.status_i = 32'h0000_0000;
      run(3);

      // Async reset while requesting.
      bus.status_i = 32'h0000_0401;
      bus.irq_i    = 6'b000001;
      run(4);
      #2 rst = 1'b1;
      #1 model_reset();
      check_all();
      run(2);
      bus.irq_i = 6'd0;
      rst = 1'b0;
      run(6);

      // Random traffic.
      for (int n = 0; n < 2500; n++) begin
         if ($urandom_range(0, 7) == 0) bus.irq_i = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 15) == 0) begin
            bus.status_i = $urandom;
            bus.status_i[0] = ($urandom_range(0, 3) != 0);
         end
         bus.ack_i  = ($urandom_range(0, 2) == 0);
         bus.eret_i = ($urandom_range(0, 3) == 0);
         bus.pc_i   = $urandom;
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
